// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings and FSM states for the data memory.
package mem_pkg;
  typedef enum logic [1:0] {MEM_NONE = 2'b00, MEM_BYTE = 2'b01, MEM_HALF = 2'b10, MEM_WORD = 2'b11} mem_size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
endpackage

// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if: MA-stage request/response bundle between cpu and data memory.
interface data_memory_unit_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic        load_unsigned;
  logic [31:0] read_data;
  logic        busy_wait;
  logic        misaligned;
  modport master (output address, write_data, mem_read, mem_write, load_unsigned,
                  input read_data, busy_wait, misaligned);
  modport slave (input address, write_data, mem_read, mem_write, load_unsigned,
                 output read_data, busy_wait, misaligned);
endinterface

// File: rtl/load_store_align.sv
// load_store_align: byte enables, store lane replication, load extraction/extension, misalignment.
module load_store_align
  import mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        load_unsigned,
  output logic [3:0]  byte_en,
  output logic [31:0] wlanes,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [31:0] shifted;
  always_comb begin
    misaligned = (size == MEM_HALF && lane[0]) || (size == MEM_WORD && lane != 2'b00);
    byte_en = size == MEM_BYTE ? 4'b0001 << lane :
              size == MEM_HALF ? (lane[1] ? 4'b1100 : 4'b0011) :
              size == MEM_WORD ? 4'b1111 : 4'b0000;
    wlanes = size == MEM_BYTE ? {4{wdata[7:0]}} : size == MEM_HALF ? {2{wdata[15:0]}} : wdata;
    shifted = size == MEM_HALF ? rword >> {lane[1], 4'b0} : rword >> {lane, 3'b0};
    rdata = size == MEM_BYTE ? {{24{~load_unsigned & shifted[7]}}, shifted[7:0]} :
            size == MEM_HALF ? {{16{~load_unsigned & shifted[15]}}, shifted[15:0]} : rword;
  end
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: multi-cycle RV32 data RAM that stalls the pipeline until each access completes.
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic clk,
  input logic reset,
  data_memory_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d, read_data_q, read_data_d;
  mem_size_e     size_q, size_d;
  logic          write_q, write_d, both_q, both_d, lu_q, lu_d, mis_q, mis_d;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [3:0]    byte_en;
  logic [31:0]   wlanes, rdata;
  logic          mis, fire;
  load_store_align u_align (
    .size(size_q), .lane(addr_q[1:0]), .wdata(wdata_q), .rword(mem[addr_q[AW+1:2]]),
    .load_unsigned(lu_q), .byte_en, .wlanes, .rdata, .misaligned(mis)
  );
  assign bus.read_data  = read_data_q;
  assign bus.misaligned = mis_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    write_d     = write_q;
    both_d      = both_q;
    lu_d        = lu_q;
    read_data_d = read_data_q;
    mis_d       = 1'b0;
    fire        = state_q == ACCESS && cnt_q == '0;
    bus.busy_wait = state_q == ACCESS || (state_q == IDLE && (bus.mem_read != 2'b00 || bus.mem_write != 2'b00));
    if (state_q == IDLE && bus.busy_wait) begin
      state_d = ACCESS;
      cnt_d   = CW'(LATENCY - 1);
      addr_d  = bus.address[AW+1:0];
      wdata_d = bus.write_data;
      write_d = bus.mem_write != 2'b00;
      both_d  = write_d && bus.mem_read != 2'b00;
      size_d  = mem_size_e'(write_d ? bus.mem_write : bus.mem_read);
      lu_d    = bus.load_unsigned;
    end
    if (state_q == ACCESS) begin
      cnt_d       = fire ? cnt_q : cnt_q - 1'b1;
      state_d     = fire ? DONE : ACCESS;
      read_data_d = fire ? (write_q || mis ? '0 : rdata) : read_data_q;
      mis_d       = fire && mis && !both_q;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      write_q     <= write_d;
      both_q      <= both_d;
      lu_q        <= lu_d;
      read_data_q <= read_data_d;
      mis_q       <= mis_d;
    end
  end
  // RAM is deliberately outside reset; a reset landing on the commit edge suppresses the store.
  always_ff @(posedge clk) begin
    if (!reset && fire && write_q && !mis)
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: randomized bench against a byte-array transaction model of the data memory.
module tb_data_memory_unit;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic reset = 1'b1;
  data_memory_unit_if bus ();
  data_memory_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int passed = 0;
  int total = 0;
  bit chk_on = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_mis = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [7:0]  mb [DEPTH*4];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy_wait", {31'b0, bus.busy_wait}, {31'b0, exp_busy});
      check("read_data", bus.read_data, exp_rd);
      check("misaligned", {31'b0, bus.misaligned}, {31'b0, exp_mis});
    end
  end
  function automatic int nbytes(input logic [1:0] c);
    return c == 2'd1 ? 1 : c == 2'd2 ? 2 : 4;
  endfunction
  // Transaction-level model: little-endian byte array, address taken modulo the RAM size.
  task automatic model(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d,
                       input logic lu, output logic [31:0] r, output logic m);
    int n;
    int base;
    logic [31:0] v;
    n = nbytes(wr != 2'b00 ? wr : rd);
    base = int'(a % (DEPTH * 4));
    m = (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
    r = '0;
    if (wr != 2'b00) begin
      if (!m) for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
      if (rd != 2'b00) m = 1'b0;
    end else if (!m) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (n < 4 && !lu && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      r = v;
    end
  endtask
  task automatic clear_inputs();
    bus.mem_read = 2'b00;
    bus.mem_write = 2'b00;
    bus.address = '0;
    bus.write_data = '0;
    bus.load_unsigned = 1'b0;
  endtask
  task automatic txn(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d,
                     input logic lu, input bit abort, input bit lit, input logic [31:0] lit_rd,
                     input logic lit_mis, input string nm);
    logic [31:0] r;
    logic m;
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.address = a;
    bus.write_data = d;
    bus.load_unsigned = lu;
    exp_busy = 1'b1;
    exp_mis = 1'b0;
    @(posedge clk); #1;
    if (abort) begin
      reset = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      reset = 1'b0;
      exp_busy = 1'b0;
      exp_rd = '0;
      return;
    end
    repeat (LAT - 1) begin
      @(posedge clk); #1;
    end
    model(rd, wr, a, d, lu, r, m);
    @(posedge clk); #1;
    exp_busy = 1'b0;
    exp_rd = r;
    exp_mis = m;
    if (lit) begin
      check({nm, " data"}, bus.read_data, lit_rd);
      check({nm, " misaligned"}, {31'b0, bus.misaligned}, {31'b0, lit_mis});
    end
    @(posedge clk); #1;
    clear_inputs();
    exp_mis = 1'b0;
  endtask
  task automatic op(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d, input logic lu);
    txn(rd, wr, a, d, lu, 1'b0, 1'b0, '0, 1'b0, "");
  endtask
  task automatic opl(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d,
                     input logic lu, input logic [31:0] lit_rd, input logic lit_mis, input string nm);
    txn(rd, wr, a, d, lu, 1'b0, 1'b1, lit_rd, lit_mis, nm);
  endtask
  initial begin
    int sel;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_on = 1'b1;
    check("reset read_data", bus.read_data, 32'h0);
    check("reset busy_wait", {31'b0, bus.busy_wait}, 32'h0);
    for (int i = 5; i < DEPTH; i++) op(2'b00, 2'b11, 32'(i * 4), $urandom, 1'b0);
    op(2'b00, 2'b11, 32'h00, 32'h0000_00AA, 1'b0);
    op(2'b00, 2'b11, 32'h04, 32'h8081_F0BB, 1'b0);
    op(2'b00, 2'b11, 32'h08, 32'h0000_00CC, 1'b0);
    op(2'b00, 2'b11, 32'h0C, 32'h0000_00DD, 1'b0);
    op(2'b00, 2'b11, 32'h10, 32'h0000_00EE, 1'b0);
    opl(2'b11, 2'b00, 32'h08, '0, 1'b0, 32'h0000_00CC, 1'b0, "LW 0x08");
    opl(2'b01, 2'b00, 32'h05, '0, 1'b0, 32'hFFFF_FFF0, 1'b0, "LB 0x05");
    opl(2'b01, 2'b00, 32'h05, '0, 1'b1, 32'h0000_00F0, 1'b0, "LBU 0x05");
    opl(2'b10, 2'b00, 32'h06, '0, 1'b0, 32'hFFFF_8081, 1'b0, "LH 0x06");
    opl(2'b10, 2'b00, 32'h06, '0, 1'b1, 32'h0000_8081, 1'b0, "LHU 0x06");
    op(2'b00, 2'b01, 32'h0E, 32'hA5A5_A57F, 1'b0);
    opl(2'b11, 2'b00, 32'h0C, '0, 1'b0, 32'h007F_00DD, 1'b0, "LW after SB");
    op(2'b00, 2'b10, 32'h0C, 32'h1234_BEEF, 1'b0);
    opl(2'b11, 2'b00, 32'h0C, '0, 1'b0, 32'h007F_BEEF, 1'b0, "LW after SH");
    opl(2'b00, 2'b11, 32'h0A, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, "SW misaligned");
    opl(2'b11, 2'b00, 32'h08, '0, 1'b0, 32'h0000_00CC, 1'b0, "LW after bad SW");
    opl(2'b10, 2'b00, 32'h07, '0, 1'b0, 32'h0, 1'b1, "LH misaligned");
    opl(2'b11, 2'b00, 32'h400, '0, 1'b0, 32'h0000_00AA, 1'b0, "LW wrap");
    txn(2'b00, 2'b11, 32'h10, 32'h1234_5678, 1'b0, 1'b1, 1'b0, '0, 1'b0, "SW aborted");
    check("abort busy_wait", {31'b0, bus.busy_wait}, 32'h0);
    check("abort read_data", bus.read_data, 32'h0);
    opl(2'b11, 2'b00, 32'h10, '0, 1'b0, 32'h0000_00EE, 1'b0, "LW after abort");
    op(2'b00, 2'b11, 32'h10, 32'h1234_5678, 1'b0);
    opl(2'b11, 2'b00, 32'h10, '0, 1'b0, 32'h1234_5678, 1'b0, "LW back-to-back");
    opl(2'b11, 2'b11, 32'h14, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, "RW both");
    opl(2'b11, 2'b00, 32'h14, '0, 1'b0, 32'hCAFE_F00D, 1'b0, "LW after RW");
    opl(2'b01, 2'b11, 32'h21, 32'h0BAD_0BAD, 1'b0, 32'h0, 1'b0, "RW both misaligned");
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) op(2'($urandom_range(1, 3)), 2'b00, $urandom_range(0, 2047), $urandom, 1'($urandom));
      else if (sel <= 6) op(2'b00, 2'($urandom_range(1, 3)), $urandom_range(0, 2047), $urandom, 1'($urandom));
      else if (sel == 7) op(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), $urandom_range(0, 2047), $urandom, 1'($urandom));
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
